irq_pending_latch: RTL
======================

# irq_pending_latch

Request-capture stage that sits directly upstream of the 8-to-3 priority encoder. It synchronises eight asynchronous request lines and turns rising edges (or levels) into sticky pending bits. It presents the highest-priority enabled request as a 3-bit index under a valid/ack handshake, and clears that bit only when the consumer acknowledges it. Bit 7 has the highest priority and bit 0 the lowest, the same ordering as the encoder.

## Interface
Parameters:
- EDGE, 1, 1 = rising-edge capture, 0 = level capture
- SYNC_STAGES, 2, synchroniser depth on req (legal values 2 or 3)

Ports:
- clk  in  1  single clock, all state on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  8  asynchronous request lines
- en  in  8  per-bit enable mask; bit=0 blocks offering but does not block capture
- ack  in  1  consumer accepts the current idx; ignored while valid=0
- ovf_clr  in  1  one-cycle pulse that clears all ovf bits
- valid  out  1  idx holds an offered request
- idx  out  3  encoded request number, binary 0..7
- pending  out  8  raw pending register, unmasked
- ovf  out  8  sticky per-bit lost-event flags

## Operation
- Synchroniser: SYNC_STAGES flops per bit, then one history flop (hist). All reset to 0.
- A req held high through reset is seen as a rising edge after reset release.
- Edge mode (EDGE=1):
  - rise[i] = sync[i] & ~hist[i].
  - rise sets pending[i].
  - rise while pending[i] is already 1 sets ovf[i].
- Level mode (EDGE=0):
  - pending[i] is set every cycle that sync[i]=1.
  - ovf is tied to 0.
- Ack clears pending[idx]. If a set and a clear hit the same bit in the same cycle, set wins and the new event is kept.
- ovf_clr clears ovf. An ovf set in the same cycle wins over ovf_clr.
- Offer logic uses m = pending & en and picks the highest set bit of m.
- FSM states:
  - IDLE (valid=0): if m≠0, load idx with the encoded value of m, set valid=1, go to OFFER. Otherwise stay in IDLE.
  - OFFER (valid=1): idx and valid are frozen. A newly pending higher-priority request does not preempt the offer, and a mask change does not withdraw it. On ack, clear pending[idx], set valid=0 and go to IDLE.
- Every grant passes through at least one IDLE cycle, so the peak rate is one grant per 2 cycles.

## Timing
- Reset values: valid=0, idx=3'b000, pending=8'h00, ovf=8'h00, FSM=IDLE.
- Reset is asynchronous on assertion and takes effect mid-offer: valid drops immediately and the request is lost.
- Latency with SYNC_STAGES=2, edge 0 = first edge that samples req=1:
  - pending[i] is set at edge 2.
  - valid rises at edge 3 if the FSM is IDLE and en[i]=1.
  - Each extra sync stage adds 1 cycle.
- Handshake:
  - A transfer occurs on the edge where valid & ack are both 1.
  - valid is low for the following cycle.
  - The next offer appears at the edge after that, if m≠0.
- A request whose en bit is 0 stays pending indefinitely. It is offered at the first IDLE edge after en goes to 1.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Shared package / header irq_defs:
  - N_REQ=8, IDX_W=3
  - FSM state encodings: IDLE=1'b0, OFFER=1'b1
- One sub-module, prio_enc8:
  - purely combinational 8→3 highest-bit-wins encoder plus an any-bit output.
  - instantiated on m.
- The synchroniser is inline generate logic, not a separate module.

## Test plan
- Reset, then pulse req=8'h01 for 3 cycles:
  - pending=8'h01 at edge 2, valid=1 with idx=0 at edge 3.
  - ack at edge 5 → valid=0 and pending=8'h00 at edge 5.
- Raise req bits 2 and 6 together with en=8'hFF:
  - First offer idx=6. After ack, one idle cycle, then idx=2.
  - After the second ack, pending=0.
- While idx=1 is offered, raise req bit 7:
  - idx stays 1 until ack.
  - The next offer is idx=7.
- Edge mode, pending[3]=1, produce a second rise on bit 3:
  - ovf=8'h08.
  - ovf_clr pulse → ovf=0.
  - Only one grant for bit 3.
- With en=8'h00, raise req bit 4:
  - pending=8'h10, valid stays 0 for 20 cycles.
  - en=8'h10 → valid=1, idx=4 one edge later.
- Assert rst_n=0 mid-OFFER with pending=8'h81:
  - All outputs go to reset values immediately.
  - req still held high after release → re-offered at edge 3 after release.

Source files
------------

// File: rtl/irq_defs.sv
`default_nettype none
// ============================================================================
// Package  : irq_defs
// Purpose  : Shared widths, FSM state encoding and a small index-to-mask
//            helper for the interrupt pending latch and its priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
package irq_defs;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // One-hot mask selecting the request numbered by idx.
  function automatic logic [N_REQ-1:0] idx_to_mask(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage : irq_defs
`default_nettype wire

// File: rtl/prio_enc8.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc8
// Purpose  : Combinational 8-to-3 priority encoder, highest set bit wins.
// Ports    : in  [7:0] - request vector (bit 7 = highest priority)
//            idx [2:0] - number of the highest set bit (0 when in == 0)
//            any       - at least one bit of in is set
// Revision : 1.0 - initial release
// ============================================================================
module prio_enc8
  import irq_defs::*;
(
  input  logic [N_REQ-1:0] in,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    // Ascending scan so the last (highest) set bit overrides the others.
    for (int i = 0; i < N_REQ; i++) begin
      if (in[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign any = |in;

endmodule : prio_enc8
`default_nettype wire

// File: rtl/irq_pending_latch.sv
`default_nettype none
// ============================================================================
// Module   : irq_pending_latch
// Purpose  : Synchronises eight asynchronous request lines, converts rising
//            edges (or levels) into sticky pending bits and offers the
//            highest-priority enabled pending request under a valid/ack
//            handshake. A pending bit is cleared only when acknowledged.
// Params   : EDGE        - 1 = rising-edge capture, 0 = level capture
//            SYNC_STAGES - synchroniser depth on req (2 or 3)
// Ports    : clk      - clock, all state on the rising edge
//            rst_n    - asynchronous active-low reset
//            req      - asynchronous request lines
//            en       - offer mask (does not block capture)
//            ack      - consumer accepts idx (ignored while valid = 0)
//            ovf_clr  - pulse clearing all overflow flags
//            valid    - idx holds an offered request
//            idx      - encoded request number
//            pending  - raw pending register
//            ovf      - sticky per-bit lost-event flags
// Revision : 1.0 - initial release
// ============================================================================
module irq_pending_latch
  import irq_defs::*;
#(
  parameter int EDGE        = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] en,
  input  logic             ack,
  input  logic             ovf_clr,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] ovf
);

  // --------------------------------------------------------------------------
  // Synchroniser chain plus history flop. Everything resets to 0, so a request
  // held high through reset appears as a fresh rising edge after release.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][N_REQ-1:0] sync_q;
  logic [N_REQ-1:0]                  sync;
  logic [N_REQ-1:0]                  hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req};
      hist   <= sync;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Capture: set vector for the pending register and overflow flags.
  // --------------------------------------------------------------------------
  logic [N_REQ-1:0] set_bits;
  logic [N_REQ-1:0] clr_bits;

  generate
    if (EDGE != 0) begin : g_edge
      logic [N_REQ-1:0] rise;
      logic [N_REQ-1:0] ovf_set;

      assign rise     = sync & ~hist;
      assign set_bits = rise;
      // A new edge on a bit that is still pending is a lost event, even if
      // that bit is being acknowledged in this very cycle.
      assign ovf_set  = rise & pending;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf <= '0;
        end else begin
          // Set has priority over the clear pulse.
          ovf <= (ovf & ~{N_REQ{ovf_clr}}) | ovf_set;
        end
      end
    end else begin : g_level
      assign set_bits = sync;
      assign ovf      = '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Pending register. Set wins over an acknowledge clear on the same bit.
  // --------------------------------------------------------------------------
  state_t state;
  state_t state_nx;

  assign clr_bits = ((state == OFFER) && ack) ? idx_to_mask(idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_bits) | set_bits;
    end
  end

  // --------------------------------------------------------------------------
  // Offer selection on the enabled pending bits.
  // --------------------------------------------------------------------------
  logic [N_REQ-1:0] m;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;

  assign m = pending & en;

  prio_enc8 u_prio_enc8 (
    .in  (m),
    .idx (enc_idx),
    .any (enc_any)
  );

  // --------------------------------------------------------------------------
  // Handshake FSM. idx is loaded only when leaving IDLE and is frozen while
  // an offer is outstanding, so neither a higher-priority arrival nor a mask
  // change disturbs an offer already presented.
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] idx_nx;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        if (enc_any) begin
          idx_nx   = enc_idx;
          state_nx = OFFER;
        end
      end
      OFFER: begin
        if (ack) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  assign valid = (state == OFFER);

endmodule : irq_pending_latch
`default_nettype wire
